// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder. The master side issues
// start with operands; the slave side reports busy/done and the result.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Full adder built from two half adders; the single bit slice used by the
// serial adder controller.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module FA_using_HA (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1),  .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(sum), .c(c2));

    assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures a, b, cin on an accepted start,
// adds one bit per RUN cycle LSB first through a single full adder, then
// publishes sum/cout and pulses done for one cycle.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    // Counter must hold values 0..WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             fa_s;
    logic             fa_co;

    FA_using_HA u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                res_sh_d            = res_sh_q >> 1;
                res_sh_d[WIDTH-1]   = fa_s;
                carry_d             = fa_co;
                cnt_d               = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = res_sh_d;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered from the next state so they line up
        // with the state they describe and have no input-to-output path.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8 main instance, WIDTH=1 corner
// instance). Inputs are driven and outputs sampled on the falling edge.
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus  ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;
    vec_t         vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete operation, checking latency, busy length, single done
    // pulse, result hold during RUN and the final result.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es, input logic ec,
                          input bit repulse);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_off = -1;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        for (int off = 0; off < W + 4; off++) begin
            @(negedge clk);
            if (off == 0) begin
                bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
            end
            if (repulse && off == 2) begin
                bus.start = 1'b1; bus.a = 8'hC3; bus.b = 8'h77; bus.cin = 1'b1;
            end
            if (repulse && off == 3) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_off < 0) done_off = off;
            end
            if (off == W - 1) begin
                check($sformatf("%s.hold_sum", name), 64'(bus.sum), 64'(last_sum));
                check($sformatf("%s.hold_cout", name), 64'(bus.cout), 64'(last_cout));
            end
        end
        check($sformatf("%s.done_latency", name), 64'(done_off), 64'(W));
        check($sformatf("%s.done_count", name), 64'(done_cnt), 64'd1);
        check($sformatf("%s.busy_cycles", name), 64'(busy_cnt), 64'(W + 1));
        check($sformatf("%s.sum", name), 64'(bus.sum), 64'(es));
        check($sformatf("%s.cout", name), 64'(bus.cout), 64'(ec));
        last_sum  = es;
        last_cout = ec;
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] e;
        int         cyc;
        int         last_done;
        int         got;
        int         seen_done;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

        // Reset state, with start high to show reset wins.
        rst = 1'b1;
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.sum",  64'(bus.sum),  64'd0);
        check("reset.cout", 64'(bus.cout), 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout, 1'b0);
        end

        // start re-pulsed during RUN with different operands.
        run_op("repulse", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b1);

        // Reset on the 4th RUN cycle aborts with no done.
        @(negedge clk);
        bus.a = 8'h3C; bus.b = 8'h0F; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.sum",  64'(bus.sum),  64'd0);
        check("abort.cout", 64'(bus.cout), 64'd0);
        rst = 1'b0;
        seen_done = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done) seen_done = 1;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);
        last_sum = '0; last_cout = 1'b0;
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // start held high with random operands; throughput and results.
        cyc = 0; last_done = -1; got = 0;
        while (got < 200 && cyc < 200 * (W + 2) + 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                if (q.size() == 0) begin
                    check("cont.queue_empty", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("cont%0d.result", got), 64'({bus.cout, bus.sum}), 64'(e));
                end
                if (last_done >= 0)
                    check($sformatf("cont%0d.spacing", got), 64'(cyc - last_done), 64'(W + 2));
                last_done = cyc;
                got++;
            end
            bus.start = 1'b1;
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.cin = 1'($urandom);
            if (!bus.busy)
                q.push_back((W+1)'(bus.a) + (W+1)'(bus.b) + (W+1)'(bus.cin));
        end
        check("cont.done_total", 64'(got), 64'd200);
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);

        // WIDTH=1 instance: one RUN cycle then DONE.
        @(negedge clk);
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;
        check("w1.run_busy", 64'(bus1.busy), 64'd1);
        check("w1.run_done", 64'(bus1.done), 64'd0);
        @(negedge clk);
        check("w1.done",  64'(bus1.done), 64'd1);
        check("w1.sum",   64'(bus1.sum),  64'd1);
        check("w1.cout",  64'(bus1.cout), 64'd1);
        @(negedge clk);
        check("w1.idle_busy", 64'(bus1.busy), 64'd0);
        check("w1.idle_done", 64'(bus1.done), 64'd0);
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        @(negedge clk);
        check("w1b.done", 64'(bus1.done), 64'd1);
        check("w1b.sum",  64'(bus1.sum),  64'd1);
        check("w1b.cout", 64'(bus1.cout), 64'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  rising-edge clock, only clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request one addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007 cin  input  1  carry-in, captured on the accepted start edge.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
REQ-010 sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-011 cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 The block SHALL compute the sum bit-serially, LSB first, through exactly one full-adder instance, one bit per RUN cycle.
REQ-013 States SHALL be IDLE, RUN and DONE; no other states are reachable.
REQ-014 IDLE with start=1 at an edge: capture a, b and cin into shift/carry registers; clear the bit counter; go to RUN.
REQ-015 IDLE with start=0 at an edge: stay in IDLE; the internal registers and outputs hold their values.
REQ-016 RUN at each edge: feed bit 0 of the A/B shift registers and the carry register to the full adder; shift its sum bit into the MSB of a result shift register; update the carry register; increment the counter.
REQ-017 RUN at the edge that processes bit WIDTH-1: load sum from the completed result, load cout from the final carry, and go to DONE.
REQ-018 DONE: assert done for exactly this one cycle, then go to IDLE at the next edge unconditionally.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-020 The next start SHALL be accepted no earlier than one cycle after done, giving a throughput of one operation per WIDTH+2 cycles.
REQ-021 start SHALL be ignored in RUN and DONE; a, b and cin SHALL be ignored outside the accepting edge.
REQ-022 sum and cout SHALL change only at the completion edge; they hold the last result through IDLE and throughout the next RUN.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and never wrap within one operation.
REQ-024 WIDTH=1 SHALL work: a single RUN cycle, then DONE.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, shift registers and carry register.
REQ-026 rst asserted during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst is deasserted SHALL proceed normally.
REQ-027 rst SHALL take priority over start at the same edge.

Structure
REQ-028 The shared package serial_add_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 The single bit-slice sub-module SHALL be the team's existing full adder, FA_using_HA, instantiated once.
REQ-030 The controller SHALL contain no combinational path from any input to any output.

Verification (WIDTH=8)
REQ-031 Inputs a=8'h3C, b=8'h0F, cin=0, start pulsed -> sum=8'h4B, cout=0, done high exactly 8 cycles after the start edge, busy high for 9 cycles.
REQ-032 Inputs a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; inputs a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1.
REQ-033 start re-pulsed with new operands during RUN -> the new operands are ignored, exactly one done pulse occurs, and the result matches the first operands.
REQ-034 rst asserted on the 4th RUN cycle -> the next cycle has busy=0, done=0, sum=0, cout=0; a following operation a=8'h01, b=8'h01 yields sum=8'h02.
REQ-035 start held high continuously with 200 random a/b/cin sets -> each done occurs WIDTH+2 cycles apart, and each {cout,sum} equals a+b+cin from a reference model.
